// File: rtl/miniRISC_ctrl_pkg.sv
// rtl/miniRISC_ctrl_pkg.sv - shared types, opcode map and control-word helpers for multicycle_control
// S_TRAP only exists when CTRL_ILLEGAL_TRAP_EN is defined.
package miniRISC_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
`ifdef CTRL_ILLEGAL_TRAP_EN
      , S_TRAP
`endif
   } state_t;

   typedef enum logic [2:0] {
      CL_ALU,
      CL_LOAD,
      CL_STORE,
      CL_BR,
      CL_BL,
      CL_ILLEGAL
   } class_t;

   localparam int OP_BITS = 6;
   localparam int FN_BITS = 6;

   localparam logic [5:0] OP_ALU0  = 6'd0;
   localparam logic [5:0] OP_ALU1  = 6'd1;
   localparam logic [5:0] OP_ALU2  = 6'd2;
   localparam logic [5:0] OP_LOAD  = 6'd3;
   localparam logic [5:0] OP_STORE = 6'd4;
   localparam logic [5:0] OP_ALU5  = 6'd5;
   localparam logic [5:0] OP_ALUI  = 6'd6;
   localparam logic [5:0] OP_ALUIS = 6'd7;
   localparam logic [5:0] OP_BR    = 6'd8;
   localparam logic [5:0] OP_JR    = 6'd9;
   localparam logic [5:0] OP_BC0   = 6'd10;
   localparam logic [5:0] OP_BC1   = 6'd11;
   localparam logic [5:0] OP_BC2   = 6'd12;
   localparam logic [5:0] OP_BL    = 6'd13;
   localparam logic [5:0] OP_BR14  = 6'd14;
   localparam logic [5:0] OP_BR15  = 6'd15;

   localparam logic [3:0] ALU_NONE = 4'd0;
   localparam logic [3:0] ALU_OP1  = 4'd1;
   localparam logic [3:0] ALU_OP2  = 4'd2;
   localparam logic [3:0] ALU_OP3  = 4'd3;
   localparam logic [3:0] ALU_OP4  = 4'd4;
   localparam logic [3:0] ALU_OP6  = 4'd6;
   localparam logic [3:0] ALU_OP7  = 4'd7;
   localparam logic [3:0] ALU_MEM  = 4'd8;
   localparam logic [3:0] ALU_OP9  = 4'd9;

   typedef struct packed {
      logic [1:0] rdst;
      logic [1:0] mreg;
      logic [3:0] aluop;
      logic       alusr;
      logic       alusw;
      logic       jad;
      logic       jb;
   } ctrl_word_t;

   function automatic ctrl_word_t mk_cw(input logic [3:0] aluop, input logic alusr,
                                        input logic alusw);
      ctrl_word_t cw;
      cw       = '0;
      cw.aluop = aluop;
      cw.alusr = alusr;
      cw.alusw = alusw;
      return cw;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode/funct to control word and instruction class table
module ctrl_decode
   import miniRISC_ctrl_pkg::*;
(
   input  logic [OP_BITS-1:0] i_opcode,
   input  logic [FN_BITS-1:0] i_funct,
   output ctrl_word_t         o_cw,
   output class_t             o_cls
);

   always_comb begin
      o_cw  = '0;
      o_cls = CL_ILLEGAL;
      case (i_opcode)
         OP_ALU0: begin
            case (i_funct)
               6'd0:    begin o_cw = mk_cw(ALU_OP1, 1'b0, 1'b0); o_cls = CL_ALU; end
               6'd1:    begin o_cw = mk_cw(ALU_OP1, 1'b0, 1'b1); o_cls = CL_ALU; end
               default: ;
            endcase
         end
         OP_ALU1: begin
            case (i_funct)
               6'd0:    begin o_cw = mk_cw(ALU_OP2, 1'b0, 1'b0); o_cls = CL_ALU; end
               6'd1:    begin o_cw = mk_cw(ALU_OP3, 1'b0, 1'b0); o_cls = CL_ALU; end
               default: ;
            endcase
         end
         OP_ALU2: begin
            case (i_funct)
               6'd0:    begin o_cw = mk_cw(ALU_OP4, 1'b1, 1'b0); o_cls = CL_ALU; end
               6'd1:    begin o_cw = mk_cw(ALU_OP6, 1'b1, 1'b0); o_cls = CL_ALU; end
               6'd2:    begin o_cw = mk_cw(ALU_OP4, 1'b0, 1'b0); o_cls = CL_ALU; end
               6'd3:    begin o_cw = mk_cw(ALU_OP6, 1'b0, 1'b0); o_cls = CL_ALU; end
               6'd4:    begin o_cw = mk_cw(ALU_OP7, 1'b1, 1'b0); o_cls = CL_ALU; end
               6'd5:    begin o_cw = mk_cw(ALU_OP7, 1'b0, 1'b0); o_cls = CL_ALU; end
               default: ;
            endcase
         end
         OP_LOAD: begin
            o_cw      = mk_cw(ALU_MEM, 1'b1, 1'b0);
            o_cw.rdst = 2'd1;
            o_cw.mreg = 2'd1;
            o_cls     = CL_LOAD;
         end
         OP_STORE: begin o_cw = mk_cw(ALU_MEM, 1'b1, 1'b0); o_cls = CL_STORE; end
         OP_ALU5:  begin o_cw = mk_cw(ALU_OP9, 1'b0, 1'b0); o_cls = CL_ALU;   end
         OP_ALUI:  begin o_cw = mk_cw(ALU_OP1, 1'b1, 1'b0); o_cls = CL_ALU;   end
         OP_ALUIS: begin o_cw = mk_cw(ALU_OP1, 1'b1, 1'b1); o_cls = CL_ALU;   end
         OP_BR, OP_BR14, OP_BR15: o_cls = CL_BR;
         OP_JR: begin o_cw.jad = 1'b1; o_cls = CL_BR; end
         OP_BC0, OP_BC1, OP_BC2: begin o_cw.jb = 1'b1; o_cls = CL_BR; end
         OP_BL: begin
            o_cw.rdst = 2'd2;
            o_cw.mreg = 2'd2;
            o_cls     = CL_BL;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - FETCH/DECODE/EXEC/MEM/WB control FSM with retired-instruction counter
// CTRL_ILLEGAL_TRAP_EN: illegal instructions lock the FSM in S_TRAP instead of retiring as NOPs.
module multicycle_control
   import miniRISC_ctrl_pkg::*;
#(
   parameter int OPW    = 6,
   parameter int FNW    = 6,
   parameter int ALUOPW = 4,
   parameter int CNTW   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OPW-1:0]    opcode,
   input  logic [FNW-1:0]    funct,
   input  logic              imem_ack,
   input  logic              dmem_ack,
   output logic              imem_req,
   output logic              ir_write,
   output logic              pc_write,
   output logic [1:0]        RDst,
   output logic [1:0]        MReg,
   output logic [ALUOPW-1:0] ALUOp,
   output logic              ALUSr,
   output logic              ALUSw,
   output logic              JAd,
   output logic              JB,
   output logic              RWrite,
   output logic              MR,
   output logic              MW,
   output logic              Branch,
   output logic              instr_done,
   output logic [CNTW-1:0]   instret,
   output logic              illegal
);

   state_t          r_state, w_next;
   ctrl_word_t      r_cw, w_cw;
   class_t          r_cls, w_cls;
   logic [CNTW-1:0] r_instret;

   ctrl_decode u_decode (
      .i_opcode (OP_BITS'(opcode)),
      .i_funct  (FN_BITS'(funct)),
      .o_cw     (w_cw),
      .o_cls    (w_cls)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_cw      <= '0;
         r_cls     <= CL_ALU;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_cw  <= w_cw;
            r_cls <= w_cls;
         end
         if (instr_done)
            r_instret <= r_instret + 1'b1;
      end
   end

   always_comb begin
      w_next     = r_state;
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      RWrite     = 1'b0;
      MR         = 1'b0;
      MW         = 1'b0;
      Branch     = 1'b0;
      instr_done = 1'b0;
      case (r_state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               w_next   = S_DECODE;
            end
         end
         S_DECODE: w_next = S_EXEC;
         S_EXEC: begin
            case (r_cls)
               CL_ALU:            w_next = S_WB;
               CL_LOAD, CL_STORE: w_next = S_MEM;
               CL_BR: begin
                  Branch     = 1'b1;
                  instr_done = 1'b1;
                  w_next     = S_FETCH;
               end
               CL_BL: begin
                  Branch = 1'b1;
                  w_next = S_WB;
               end
               default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                  w_next     = S_TRAP;
`else
                  instr_done = 1'b1;
                  w_next     = S_FETCH;
`endif
               end
            endcase
         end
         S_MEM: begin
            MR = (r_cls == CL_LOAD);
            MW = (r_cls != CL_LOAD);
            if (dmem_ack) begin
               if (r_cls == CL_LOAD) begin
                  w_next = S_WB;
               end else begin
                  instr_done = 1'b1;
                  w_next     = S_FETCH;
               end
            end
         end
         S_WB: begin
            RWrite     = 1'b1;
            instr_done = 1'b1;
            w_next     = S_FETCH;
         end
`ifdef CTRL_ILLEGAL_TRAP_EN
         S_TRAP: w_next = S_TRAP;
`endif
         default: w_next = S_FETCH;
      endcase
      // Strobes are silenced while reset is held so an aborted instruction leaves no side effects.
      if (rst) begin
         imem_req   = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         RWrite     = 1'b0;
         MR         = 1'b0;
         MW         = 1'b0;
         Branch     = 1'b0;
         instr_done = 1'b0;
      end
   end

   assign RDst    = r_cw.rdst;
   assign MReg    = r_cw.mreg;
   assign ALUOp   = ALUOPW'(r_cw.aluop);
   assign ALUSr   = r_cw.alusr;
   assign ALUSw   = r_cw.alusw;
   assign JAd     = r_cw.jad;
   assign JB      = r_cw.jb;
   assign instret = r_instret;

`ifdef CTRL_ILLEGAL_TRAP_EN
   assign illegal = (r_state == S_TRAP);
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed-vector bench for multicycle_control (honours CTRL_ILLEGAL_TRAP_EN)
module tb_multicycle_control;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [5:0]    opcode = '0;
   logic [5:0]    funct = '0;
   logic          imem_ack = 1'b0;
   logic          dmem_ack = 1'b0;
   logic          imem_req, ir_write, pc_write;
   logic [1:0]    RDst, MReg;
   logic [3:0]    ALUOp;
   logic          ALUSr, ALUSw, JAd, JB, RWrite, MR, MW, Branch, instr_done, illegal;
   logic [CW-1:0] instret;

   always #5 clk = ~clk;

   multicycle_control #(.CNTW(CW)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
      .RDst(RDst), .MReg(MReg), .ALUOp(ALUOp), .ALUSr(ALUSr), .ALUSw(ALUSw),
      .JAd(JAd), .JB(JB), .RWrite(RWrite), .MR(MR), .MW(MW), .Branch(Branch),
      .instr_done(instr_done), .instret(instret), .illegal(illegal)
   );

   int n_vec = 0;
   int n_err = 0;
   int exp_ret = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [5:0] op, fn;
      int         iw, dw, cyc, rw, mr, mw, br;
      logic [3:0] aluop;
      logic       sr, sw;
      logic [1:0] rdst, mreg;
      logic       jad, jb;
   } vec_t;

   localparam int NV = 13;
   vec_t vt[NV];

   int         cyc, n_rw, n_mr, n_mw, n_br, ir_at;
   logic       got_done;
   logic [3:0] s_aluop;
   logic       s_sr, s_sw, s_jad, s_jb;
   logic [1:0] s_rdst, s_mreg;

   // Memories ack after iw/dw wait cycles once the request is seen; stops at instr_done or a cycle budget.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int iw, input int dw);
      int iwait = 0;
      int dwait = 0;
      opcode = op; funct = fn;
      cyc = 0; n_rw = 0; n_mr = 0; n_mw = 0; n_br = 0; ir_at = 0; got_done = 1'b0;
      while (!got_done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         imem_ack = 1'b0; dmem_ack = 1'b0;
         #1;
         if (imem_req) begin
            if (iwait >= iw) imem_ack = 1'b1; else iwait++;
         end
         if (MR || MW) begin
            if (dwait >= dw) dmem_ack = 1'b1; else dwait++;
         end
         #1;
         if (ir_write) ir_at = cyc;
         n_rw += int'(RWrite); n_mr += int'(MR); n_mw += int'(MW); n_br += int'(Branch);
         if (instr_done) begin
            got_done = 1'b1;
            s_aluop = ALUOp; s_sr = ALUSr; s_sw = ALUSw; s_jad = JAd; s_jb = JB;
            s_rdst = RDst; s_mreg = MReg;
         end
      end
      @(posedge clk); #1;
      imem_ack = 1'b0; dmem_ack = 1'b0;
   endtask

   initial begin
      vt[0]  = '{6'd0,  6'd0, 0, 0, 4, 1, 0, 0, 0, 4'd1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
      vt[1]  = '{6'd0,  6'd1, 1, 0, 5, 1, 0, 0, 0, 4'd1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};
      vt[2]  = '{6'd2,  6'd4, 2, 0, 6, 1, 0, 0, 0, 4'd7, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
      vt[3]  = '{6'd3,  6'd0, 0, 3, 8, 1, 4, 0, 0, 4'd8, 1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0};
      vt[4]  = '{6'd4,  6'd0, 0, 2, 6, 0, 0, 3, 0, 4'd8, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
      vt[5]  = '{6'd11, 6'd0, 0, 0, 3, 0, 0, 0, 1, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
      vt[6]  = '{6'd9,  6'd5, 0, 0, 3, 0, 0, 0, 1, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
      vt[7]  = '{6'd13, 6'd0, 0, 0, 4, 1, 0, 0, 1, 4'd0, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0};
      vt[8]  = '{6'd5,  6'd9, 0, 0, 4, 1, 0, 0, 0, 4'd9, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
      vt[9]  = '{6'd4,  6'd0, 0, 0, 4, 0, 0, 1, 0, 4'd8, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
      vt[10] = '{6'd1,  6'd1, 0, 0, 4, 1, 0, 0, 0, 4'd3, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
      vt[11] = '{6'd15, 6'd3, 0, 0, 3, 0, 0, 0, 1, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
      vt[12] = '{6'd7,  6'd0, 0, 0, 4, 1, 0, 0, 0, 4'd1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};

      // Reset state
      @(negedge clk); @(negedge clk); #1;
      chk("rst_imem_req", imem_req, 0);
      chk("rst_ir_write", ir_write, 0);
      chk("rst_rwrite", RWrite, 0);
      chk("rst_instret", instret, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_aluop", ALUOp, 0);
      @(negedge clk); rst = 1'b0; #1;
      chk("rel_imem_req", imem_req, 1);

      // Two passes so the 4-bit counter wraps through all-ones
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < NV; i++) begin
            run_instr(vt[i].op, vt[i].fn, vt[i].iw, vt[i].dw);
            exp_ret = (exp_ret + 1) % 16;
            chk($sformatf("v%0d_done", i), got_done, 1);
            chk($sformatf("v%0d_cycles", i), cyc, vt[i].cyc);
            chk($sformatf("v%0d_ir_at", i), ir_at, 1 + vt[i].iw);
            chk($sformatf("v%0d_rwrite", i), n_rw, vt[i].rw);
            chk($sformatf("v%0d_mr", i), n_mr, vt[i].mr);
            chk($sformatf("v%0d_mw", i), n_mw, vt[i].mw);
            chk($sformatf("v%0d_branch", i), n_br, vt[i].br);
            chk($sformatf("v%0d_aluop", i), s_aluop, vt[i].aluop);
            chk($sformatf("v%0d_alusr", i), s_sr, vt[i].sr);
            chk($sformatf("v%0d_alusw", i), s_sw, vt[i].sw);
            chk($sformatf("v%0d_rdst", i), s_rdst, vt[i].rdst);
            chk($sformatf("v%0d_mreg", i), s_mreg, vt[i].mreg);
            chk($sformatf("v%0d_jad", i), s_jad, vt[i].jad);
            chk($sformatf("v%0d_jb", i), s_jb, vt[i].jb);
            chk($sformatf("v%0d_instret", i), instret, exp_ret);
         end
      end

      // Illegal opcode 2 / funct 7
`ifdef CTRL_ILLEGAL_TRAP_EN
      run_instr(6'd2, 6'd7, 0, 0);
      chk("trap_no_done", got_done, 0);
      chk("trap_illegal", illegal, 1);
      chk("trap_imem_req", imem_req, 0);
      chk("trap_rwrite", n_rw, 0);
      chk("trap_branch", n_br, 0);
      chk("trap_instret", instret, exp_ret);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("trap_rst_illegal", illegal, 0);
      rst = 1'b0;
      exp_ret = 0;
      #1;
      chk("trap_rel_imem_req", imem_req, 1);
`else
      run_instr(6'd2, 6'd7, 0, 0);
      exp_ret = (exp_ret + 1) % 16;
      chk("nop_done", got_done, 1);
      chk("nop_cycles", cyc, 3);
      chk("nop_rwrite", n_rw, 0);
      chk("nop_branch", n_br, 0);
      chk("nop_illegal", illegal, 0);
      chk("nop_instret", instret, exp_ret);
`endif

      // Reset during MEM of a load
      opcode = 6'd3; funct = 6'd0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         imem_ack = 1'b0; dmem_ack = 1'b0;
         #1;
         if (imem_req) imem_ack = 1'b1;
         #1;
         if (MR) break;
      end
      chk("abort_mr_seen", MR, 1);
      imem_ack = 1'b0;
      rst = 1'b1;
      #1;
      chk("abort_mr_drop", MR, 0);
      chk("abort_rwrite", RWrite, 0);
      chk("abort_done", instr_done, 0);
      chk("abort_imem_req", imem_req, 0);
      @(posedge clk); #1;
      exp_ret = 0;
      chk("abort_instret", instret, exp_ret);
      @(negedge clk); rst = 1'b0; #1;
      chk("abort_rel_imem_req", imem_req, 1);
      chk("abort_rel_mr", MR, 0);

      run_instr(6'd0, 6'd0, 0, 0);
      exp_ret = (exp_ret + 1) % 16;
      chk("post_done", got_done, 1);
      chk("post_cycles", cyc, 4);
      chk("post_instret", instret, exp_ret);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
